main_mem_responder: RTL and testbench

MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

---
 rtl/main_mem_responder_if.sv | 24 ++
 rtl/main_mem_responder.sv | 107 ++++++++++
 tb/tb_main_mem_responder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/main_mem_responder_if.sv
// Cache-controller <-> main-memory bus: read/write strobes, address, data and
// the responder's ready/busy status.
interface main_mem_responder_if #(
  parameter int ramWidth = 8,
  parameter int addrSize = 8
) ();
  logic                RAMreadEnable;
  logic                RAMwriteEnable;
  logic [addrSize-1:0] addr;
  logic [ramWidth-1:0] dataIn;
  logic [ramWidth-1:0] dataOut;
  logic                dataReady;
  logic                busy;

  modport master (
    output RAMreadEnable, RAMwriteEnable, addr, dataIn,
    input  dataOut, dataReady, busy
  );

  modport slave (
    input  RAMreadEnable, RAMwriteEnable, addr, dataIn,
    output dataOut, dataReady, busy
  );
endinterface

// File: rtl/main_mem_responder.sv
// Main-memory model answering a cache controller: zero-wait writes from IDLE,
// reads returned after a fixed latency and held while the request stays high.
module main_mem_responder #(
  parameter int ramWidth    = 8,
  parameter int addrSize    = 8,
  parameter int readLatency = 3
) (
  input logic                  clk,
  input logic                  rst,
  main_mem_responder_if.slave  bus
);

  localparam int          DEPTH  = 2 ** addrSize;
  localparam logic [3:0]  LAT_M1 = 4'(readLatency - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    READ_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [addrSize-1:0] raddr_q, raddr_d;
  logic [ramWidth-1:0] dout_q, dout_d;
  logic                rdy_q, rdy_d;
  logic                busy_q, busy_d;
  logic                mem_we;
  logic [ramWidth-1:0] mem_q [0:DEPTH-1];

  // Next-state, counter, latched address and output-register logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    raddr_d = raddr_q;
    dout_d  = dout_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.RAMwriteEnable) begin
          mem_we = ~rst;
        end else if (bus.RAMreadEnable) begin
          raddr_d = bus.addr;
          cnt_d   = LAT_M1;
          state_d = READ_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      READ_WAIT: begin
        if (!bus.RAMreadEnable) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          dout_d  = mem_q[raddr_q];
          state_d = READ_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      READ_DONE: begin
        if (!bus.RAMreadEnable) begin
          state_d = IDLE;
        end else begin
          state_d = READ_DONE;
        end
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase
    rdy_d  = (state_d == READ_DONE);
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset wins over any transfer that cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      raddr_q <= {addrSize{1'b0}};
      dout_q  <= {ramWidth{1'b0}};
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      raddr_q <= raddr_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  // Storage array, deliberately left out of reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[bus.addr] <= bus.dataIn;
    end
  end

  assign bus.dataOut   = dout_q;
  assign bus.dataReady = rdy_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Randomised + directed bench for main_mem_responder: two instances (latency 3
// and latency 1) checked every cycle against an elapsed-time reference model.
module tb_main_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  main_mem_responder_if #(.ramWidth(8), .addrSize(8)) if0 ();
  main_mem_responder_if #(.ramWidth(8), .addrSize(8)) if1 ();

  main_mem_responder #(.ramWidth(8), .addrSize(8), .readLatency(3)) dut0 (
    .clk(clk), .rst(rst), .bus(if0));
  main_mem_responder #(.ramWidth(8), .addrSize(8), .readLatency(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1));

  logic       re_v [0:1];
  logic       we_v [0:1];
  logic [7:0] ad_v [0:1];
  logic [7:0] di_v [0:1];

  assign if0.RAMreadEnable  = re_v[0];
  assign if0.RAMwriteEnable = we_v[0];
  assign if0.addr           = ad_v[0];
  assign if0.dataIn         = di_v[0];
  assign if1.RAMreadEnable  = re_v[1];
  assign if1.RAMwriteEnable = we_v[1];
  assign if1.addr           = ad_v[1];
  assign if1.dataIn         = di_v[1];

  logic       rdy_w  [0:1];
  logic       busy_w [0:1];
  logic [7:0] dout_w [0:1];
  assign rdy_w[0]  = if0.dataReady;
  assign rdy_w[1]  = if1.dataReady;
  assign busy_w[0] = if0.busy;
  assign busy_w[1] = if1.busy;
  assign dout_w[0] = if0.dataOut;
  assign dout_w[1] = if1.dataOut;

  // Reference model: a read becomes ready once LAT edges have elapsed since acceptance
  int         lat [0:1] = '{3, 1};
  logic [7:0] mmem [0:1][0:255];
  bit         act  [0:1];
  int         acc  [0:1];
  logic [7:0] ra   [0:1];
  bit         mrdy [0:1];
  logic [7:0] mdout[0:1];
  int         cyc = 0;

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, got, exp);
    else passed++;
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        act[i] = 1'b0; mrdy[i] = 1'b0; mdout[i] = 8'h00;
      end else if (!act[i]) begin
        if (we_v[i]) mmem[i][ad_v[i]] = di_v[i];
        else if (re_v[i]) begin
          act[i] = 1'b1; acc[i] = cyc; ra[i] = ad_v[i];
        end
      end else if (!re_v[i]) begin
        act[i] = 1'b0; mrdy[i] = 1'b0;
      end else if (cyc - acc[i] == lat[i]) begin
        mrdy[i] = 1'b1; mdout[i] = mmem[i][ra[i]];
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("dut%0d.dataReady", i), 32'(rdy_w[i]),  32'(mrdy[i]));
      chk($sformatf("dut%0d.busy", i),      32'(busy_w[i]), 32'(act[i]));
      chk($sformatf("dut%0d.dataOut", i),   32'(dout_w[i]), 32'(mdout[i]));
    end
  endtask

  task automatic set_both(input logic re, input logic we, input logic [7:0] a, input logic [7:0] d);
    for (int i = 0; i < 2; i++) begin
      re_v[i] = re; we_v[i] = we; ad_v[i] = a; di_v[i] = d;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; acc[i] = 0; ra[i] = 8'h00; mrdy[i] = 1'b0; mdout[i] = 8'h00;
    end
    set_both(1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    chk("reset dataReady", 32'(if0.dataReady), 32'd0);
    chk("reset busy",      32'(if0.busy),      32'd0);
    chk("reset dataOut",   32'(if0.dataOut),   32'h00);

    // Fill every word so later reads never see uninitialised memory
    for (int a = 0; a < 256; a++) begin
      set_both(1'b0, 1'b1, 8'(a), 8'($urandom));
      cycle();
    end

    // Write 0x12 then read it back with latency 3 / 1
    set_both(1'b0, 1'b1, 8'h12, 8'hA5); cycle();
    set_both(1'b1, 1'b0, 8'h12, 8'h00); cycle();
    set_both(1'b1, 1'b0, 8'h55, 8'h00); cycle();
    chk("lat1 ready after 1", 32'(if1.dataReady), 32'd1);
    chk("lat1 data",          32'(if1.dataOut),   32'hA5);
    chk("lat3 not ready @1",  32'(if0.dataReady), 32'd0);
    chk("lat3 busy @1",       32'(if0.busy),      32'd1);
    cycle();
    chk("lat3 not ready @2",  32'(if0.dataReady), 32'd0);
    cycle();
    chk("lat3 ready @3",      32'(if0.dataReady), 32'd1);
    chk("lat3 data",          32'(if0.dataOut),   32'hA5);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("hold ready", 32'(if0.dataReady), 32'd1);
      chk("hold data",  32'(if0.dataOut),   32'hA5);
    end
    set_both(1'b0, 1'b0, 8'h00, 8'h00); cycle();
    chk("drop ready", 32'(if0.dataReady), 32'd0);
    chk("drop busy",  32'(if0.busy),      32'd0);
    chk("drop keeps data", 32'(if0.dataOut), 32'hA5);

    // Both enables: write wins, read accepted one cycle later
    set_both(1'b1, 1'b1, 8'h30, 8'h5C); cycle();
    chk("collision no accept", 32'(if0.busy), 32'd0);
    set_both(1'b1, 1'b0, 8'h30, 8'h00); cycle();
    chk("collision accept", 32'(if0.busy), 32'd1);
    cycle(); cycle(); cycle();
    chk("collision read", 32'(if0.dataOut), 32'h5C);
    set_both(1'b0, 1'b0, 8'h00, 8'h00); cycle();

    // Abort from READ_WAIT, then a write pulse mid-read must be ignored
    set_both(1'b0, 1'b1, 8'h41, 8'h77); cycle();
    set_both(1'b1, 1'b0, 8'h40, 8'h00); cycle(); cycle();
    set_both(1'b0, 1'b0, 8'h40, 8'h00); cycle();
    chk("abort no ready", 32'(if0.dataReady), 32'd0);
    chk("abort idle",     32'(if0.busy),      32'd0);
    set_both(1'b1, 1'b0, 8'h41, 8'h00); cycle();
    set_both(1'b1, 1'b1, 8'h41, 8'hEE); cycle();
    set_both(1'b1, 1'b0, 8'h41, 8'h00); cycle(); cycle();
    chk("ignored write read", 32'(if0.dataOut), 32'h77);
    set_both(1'b0, 1'b0, 8'h00, 8'h00); cycle();
    set_both(1'b1, 1'b0, 8'h41, 8'h00); cycle(); cycle(); cycle(); cycle();
    chk("memory unchanged", 32'(if0.dataOut), 32'h77);
    set_both(1'b0, 1'b0, 8'h00, 8'h00); cycle();

    // Reset mid-read; memory survives reset, top address usable
    set_both(1'b0, 1'b1, 8'hFF, 8'h3C); cycle();
    set_both(1'b1, 1'b0, 8'hFF, 8'h00); cycle(); cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("rst ready", 32'(if0.dataReady), 32'd0);
    chk("rst busy",  32'(if0.busy),      32'd0);
    chk("rst data",  32'(if0.dataOut),   32'h00);
    set_both(1'b0, 1'b0, 8'h00, 8'h00);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("no stale ready", 32'(if0.dataReady), 32'd0);
    end
    set_both(1'b1, 1'b0, 8'hFF, 8'h00); cycle(); cycle(); cycle(); cycle();
    chk("post-reset read", 32'(if0.dataOut), 32'h3C);
    set_both(1'b0, 1'b0, 8'h00, 8'h00); cycle();

    // Random controller traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        int r;
        r = int'($urandom_range(0, 99));
        if (re_v[i]) re_v[i] = mrdy[i] ? (r < 50) : (r >= 8);
        else         re_v[i] = (r < 35);
        we_v[i] = ($urandom_range(0, 3) == 0);
        case ($urandom_range(0, 7))
          0:       ad_v[i] = 8'hFF;
          1:       ad_v[i] = 8'h00;
          default: ad_v[i] = 8'($urandom);
        endcase
        di_v[i] = 8'($urandom);
      end
      rst = ($urandom_range(0, 149) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
